// File: rtl/req_encoder8_if.sv
// req_encoder8_if: request/offer channel of the 8-to-3 request encoder.
//   req_n  : 8 asynchronous active-low request lines (bit i low = requester i active)
//   en     : enable for new selections
//   code   : selected index, registered
//   valid  : code holds an offered index
//   ready  : consumer accepts code on valid & ready at a rising edge
//   idle_n : low when nothing is requested and nothing is offered
// master = requester/consumer side, slave = encoder side.
interface req_encoder8_if;
  logic [7:0] req_n;
  logic       en;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic       idle_n;

  modport master (output req_n, en, ready, input code, valid, idle_n);
  modport slave  (input req_n, en, ready, output code, valid, idle_n);
endinterface

// File: rtl/req_encoder8.sv
// req_encoder8: sequential 8-to-3 request encoder.
// Synchronizes eight asynchronous active-low request lines, selects one by
// round-robin or fixed (highest-index) priority and offers its index on a
// registered valid/ready channel.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : req_encoder8_if.slave (req_n, en, ready in; code, valid, idle_n out)
// Parameters:
//   SYNC_STAGES : synchronizer depth on req_n, 2..3
//   ROUND_ROBIN : 1 = round-robin from ptr, 0 = fixed priority, highest wins

// Per-lane synchronizer; resets to 1 so a lane reads inactive out of reset.
module req_encoder8_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ff <= '1;
    else        r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];
endmodule

module req_encoder8 #(
  parameter int SYNC_STAGES = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  req_encoder8_if.slave bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_LANES-1:0]   w_req_sync;
  logic [NUM_LANES-1:0]   w_act;
  logic                   w_any;
  logic [2:0]             w_win;
  logic [2:0]             r_code, w_code_nxt;
  logic [2:0]             r_ptr, w_ptr_nxt;
  logic                   r_idle_n;
  logic                   w_valid_nxt;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    req_encoder8_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.req_n[g]),
      .o_q   (w_req_sync[g])
    );
  end

  assign w_act = ~w_req_sync;
  assign w_any = |w_act;

  // Winner select. Round-robin scans offsets from the top down so the last
  // hit is the one nearest ptr; fixed priority scans upward so the highest
  // active index is the last hit.
  always_comb begin
    logic [2:0] v_idx;
    w_win = '0;
    v_idx = '0;
    if (ROUND_ROBIN) begin
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
        v_idx = r_ptr + 3'(k);
        if (w_act[v_idx]) w_win = v_idx;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_act[i]) w_win = 3'(i);
      end
    end
  end

  // Offer FSM. Once in OFFER the index is frozen until accepted; request
  // and enable changes are ignored there. The pointer moves only on accept.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (bus.en && w_any) begin
          w_state_nxt = S_OFFER;
          w_code_nxt  = w_win;
        end
      end
      S_OFFER: begin
        if (bus.ready) begin
          w_state_nxt = S_IDLE;
          if (ROUND_ROBIN) w_ptr_nxt = r_code + 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_valid_nxt = (w_state_nxt == S_OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_ptr    <= '0;
      r_idle_n <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idle_n <= w_any | w_valid_nxt;
    end
  end

  // valid is a decode of the state flop, so reset clears it asynchronously.
  assign bus.code   = r_code;
  assign bus.valid  = (r_state == S_OFFER);
  assign bus.idle_n = r_idle_n;
endmodule

// File: tb/tb_req_encoder8.sv
module tb_req_encoder8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] d_req = 8'hFF;
  logic d_en = 1'b0;
  logic d_ready = 1'b0;

  req_encoder8_if rr_if();
  req_encoder8_if fp_if();

  assign rr_if.req_n = d_req;
  assign rr_if.en    = d_en;
  assign rr_if.ready = d_ready;
  assign fp_if.req_n = d_req;
  assign fp_if.en    = d_en;
  assign fp_if.ready = d_ready;

  req_encoder8 #(.SYNC_STAGES(S), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if.slave));
  req_encoder8 #(.SYNC_STAGES(S), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp_if.slave));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
  endtask

  // Behavioural model: index 0 = round-robin unit, index 1 = fixed priority.
  function automatic int win(input logic [7:0] act, input int ptr, input bit rr);
    if (rr) begin
      for (int k = 0; k < 8; k++) if (act[(ptr + k) % 8]) return (ptr + k) % 8;
    end else begin
      for (int i = 7; i >= 0; i--) if (act[i]) return i;
    end
    return 0;
  endfunction

  logic       m_valid[2];
  int         m_code[2];
  int         m_ptr[2];
  logic       m_idle[2];
  logic [7:0] hist[3];  // hist[j] = req_n sampled j+1 edges ago

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] <= 1'b0;
        m_code[d]  <= 0;
        m_ptr[d]   <= 0;
        m_idle[d]  <= 1'b0;
      end
      for (int j = 0; j < 3; j++) hist[j] <= 8'hFF;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d]) begin
          if (d_ready) begin
            m_valid[d] <= 1'b0;
            if (d == 0) m_ptr[d] <= (m_code[d] + 1) % 8;
          end
        end else if (d_en && (~hist[S-1] != 8'h00)) begin
          m_valid[d] <= 1'b1;
          m_code[d]  <= win(~hist[S-1], m_ptr[d], d == 0);
        end
        m_idle[d] <= (~hist[S-1] != 8'h00) ||
                     (m_valid[d] ? !d_ready : (d_en && (~hist[S-1] != 8'h00)));
      end
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= d_req;
    end
  end

  // Per-cycle compare against the model, plus a log of every new offer.
  int   log_rr[$];
  int   log_fp[$];
  logic pv_rr = 1'b0;
  logic pv_fp = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rr_valid",  int'(rr_if.valid),  int'(m_valid[0]));
      chk("rr_code",   int'(rr_if.code),   m_code[0]);
      chk("rr_idle_n", int'(rr_if.idle_n), int'(m_idle[0]));
      chk("fp_valid",  int'(fp_if.valid),  int'(m_valid[1]));
      chk("fp_code",   int'(fp_if.code),   m_code[1]);
      chk("fp_idle_n", int'(fp_if.idle_n), int'(m_idle[1]));
      if (rr_if.valid && !pv_rr) log_rr.push_back(int'(rr_if.code));
      if (fp_if.valid && !pv_fp) log_fp.push_back(int'(fp_if.code));
    end
    pv_rr <= rr_if.valid;
    pv_fp <= fp_if.valid;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_rr_valid(input string nm);
    int n = 0;
    while (!rr_if.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(rr_if.valid), 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    // Reset state
    #3;
    chk("rst_rr_valid",  int'(rr_if.valid),  0);
    chk("rst_rr_idle_n", int'(rr_if.idle_n), 0);
    chk("rst_rr_code",   int'(rr_if.code),   0);
    chk("rst_fp_valid",  int'(fp_if.valid),  0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Latency: req_n[2] first sampled at edge E
    d_en = 1'b1; d_ready = 1'b0; d_req = 8'hFB;
    @(negedge clk); chk("lat_E",    int'(rr_if.valid), 0);
    @(negedge clk); chk("lat_E1",   int'(rr_if.valid), 0);
    @(negedge clk); chk("lat_E2",   int'(rr_if.valid), 1);
    chk("lat_code", int'(rr_if.code), 2);
    d_ready = 1'b1; d_en = 1'b0; d_req = 8'hFF;
    cyc(5);

    // Backpressure: ptr is 3 now, all requesting -> offer 3
    d_en = 1'b1; d_req = 8'h00; d_ready = 1'b0;
    wait_rr_valid("bp_offer");
    chk("bp_code", int'(rr_if.code), 3);
    for (int i = 0; i < 10; i++) begin
      d_req = 8'($urandom);
      d_en  = 1'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", int'(rr_if.valid), 1);
      chk("bp_hold_code",  int'(rr_if.code),  3);
    end
    d_req = 8'h00; d_en = 1'b1;
    cyc(3);
    mark = log_rr.size();
    d_ready = 1'b1;
    cyc(4); #1;
    chk("bp_next_exists", int'(log_rr.size() > mark), 1);
    if (log_rr.size() > mark) chk("bp_ptr4", log_rr[mark], 4);

    // Reset mid-offer, then full round-robin sweep with wrap
    @(negedge clk); d_ready = 1'b0;
    wait_rr_valid("mr_offer");
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rr_valid", int'(rr_if.valid), 0);
    chk("mr_fp_valid", int'(fp_if.valid), 0);
    #1 rst_n = 1'b1;
    mark = log_rr.size();
    d_ready = 1'b1; d_req = 8'h00; d_en = 1'b1;
    @(negedge clk);
    wait_rr_valid("rr_first");
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk("rr_alt", int'(rr_if.valid), (j % 2 == 0) ? 1 : 0);
    end
    #1;
    chk("rr_count", log_rr.size() - mark, 9);
    for (int k = 0; k < 9; k++)
      if (mark + k < log_rr.size()) chk("rr_seq", log_rr[mark + k], k % 8);
    chk("fp_all7", log_fp[log_fp.size() - 1], 7);

    // Fixed priority: active 0,5,7 -> 7; release 7 -> 5
    d_req = 8'b0101_1110;
    cyc(4);
    mark = log_fp.size();
    cyc(6); #1;
    chk("fp7_count", int'(log_fp.size() - mark >= 2), 1);
    for (int k = mark; k < log_fp.size(); k++) chk("fp7", log_fp[k], 7);
    d_req = 8'b1101_1110;
    cyc(4);
    mark = log_fp.size();
    cyc(6); #1;
    chk("fp5_count", int'(log_fp.size() - mark >= 2), 1);
    for (int k = mark; k < log_fp.size(); k++) chk("fp5", log_fp[k], 5);

    // Enable gating
    @(negedge clk);
    d_en = 1'b0; d_req = 8'hFE; d_ready = 1'b1;
    cyc(5);
    chk("en_rr_valid",  int'(rr_if.valid),  0);
    chk("en_fp_valid",  int'(fp_if.valid),  0);
    chk("en_rr_idle_n", int'(rr_if.idle_n), 1);
    d_en = 1'b1;
    @(negedge clk);
    chk("en_rr_offer", int'(rr_if.valid), 1);
    chk("en_rr_code",  int'(rr_if.code),  0);
    chk("en_fp_code",  int'(fp_if.code),  0);

    // Random phase, model-checked every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      d_req   = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 3) == 0) d_req = 8'($urandom);
      d_en    = ($urandom_range(0, 3) != 0);
      d_ready = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
